branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Parametrised branch resolution and prediction block, successor to the combinational branch check.
- Resolves branch and jump conditions in EX over generic widths, with an extended condition set.
- Holds a 2-bit saturating branch history table (BHT) that IF reads, and updates it at EX.
- Drives a registered flush/redirect pulse to IF/ID on mispredict, and keeps saturating performance counters.

Parameters:
- WORD_WIDTH, 32, width of compared register values.
- PC_WIDTH, 32, width of program counter and targets.
- BHT_ENTRIES, 16, BHT depth; power of two, at least 2. IDX_BITS = log2(BHT_ENTRIES).
- PC_INC, 1, fall-through PC increment.
- CNT_WIDTH, 16, width of statistics counters.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- if_pc  in  PC_WIDTH  fetch PC; BHT index = if_pc[IDX_BITS-1:0]
- if_pred_taken  out  1  combinational prediction: MSB of BHT[if_pc index]
- ex_valid  in  1  EX holds a real instruction
- ex_pc  in  PC_WIDTH  PC of EX instruction
- ex_branch_cmd  in  3  condition code (see package)
- ex_val1, ex_val2  in  WORD_WIDTH  operand values
- ex_target  in  PC_WIDTH  taken target
- ex_pred_taken  in  1  prediction made at fetch, piped down to EX
- hazard_detected  in  1  EX stalled this cycle
- stat_clear  in  1  synchronous clear of statistics
- ex_taken  out  1  combinational resolved outcome
- flush  out  1  registered one-cycle mispredict pulse
- redirect_pc  out  PC_WIDTH  registered correct next PC, valid while flush=1
- branch_count  out  CNT_WIDTH  resolved branches
- mispredict_count  out  CNT_WIDTH  mispredictions

Behaviour:
- Reset (rst=0, async):
  - every BHT entry = 2'b01 (weakly not-taken)
  - flush=0, redirect_pc=0, both counters=0
- Conditions, combinational, for ex_taken:
  - NULL -> 0
  - JUMP -> 1
  - BEZ -> val1==0
  - BNE -> val1!=val2
  - BLT -> signed val1<val2
  - BGE -> signed val1>=val2
  - undefined codes -> 0, and treated as NULL
- resolve = ex_valid & (cmd!=NULL) & ~hazard_detected & ~flush.
  - The ~flush term squashes the wrong-path instruction sitting in EX in the cycle flush is high.
- On a clock edge with resolve=1:
  - BHT[ex_pc index]: if ex_taken, saturating increment (max 11); otherwise saturating decrement (min 00). JUMP trains as taken.
  - branch_count increments, saturating at all-ones.
  - mispredict = ex_taken != ex_pred_taken. If set, mispredict_count increments (saturating), flush<=1, redirect_pc <= ex_taken ? ex_target : ex_pc+PC_INC (mod 2^PC_WIDTH).
- Flush timing:
  - flush<=0 on every other edge, so it is at most one cycle wide and latency is 1 cycle after resolve.
  - Back-to-back flushes are impossible because of the squash.
- hazard_detected=1: no BHT, counter or flush update. ex_taken is still driven.
- Same-cycle BHT read at IF and write at EX to the same index: if_pred_taken returns the pre-update value (no bypass).
- stat_clear=1 zeroes both counters on the edge and overrides any increment that cycle. The BHT is unaffected.
- Reset asserted mid-operation clears everything immediately, including a pending flush.

Decomposition:
- Shared package, in the same defines file:
  - condition codes: NULL=3'd0, JUMP=3'd1, BEZ=3'd2, BNE=3'd3, BLT=3'd4, BGE=3'd5
  - BHT state constants SNT=00, WNT=01, WT=10, ST=11
- Sub-module bht_table, owning the counter array:
  - one async read port and one sync saturating-update port
  - parametrised by BHT_ENTRIES
  - async active-low reset to WNT

Test Plan:
- Reset, then if_pc=5 -> if_pred_taken=0. Every index reads 01.
- BEZ at ex_pc=3, val1=0, pred=0, resolve -> next cycle flush=1, redirect_pc=ex_target (e.g. 0x40), mispredict_count=1. One cycle later flush=0 and BHT[3]=10, so if_pc=3 predicts taken.
- BNE at ex_pc=7, val1=val2=9, pred=1 -> flush=1, redirect_pc=8. BHT[7] goes 01->00, then with four more not-taken stays 00.
- BLT with val1=-1 (0xFFFFFFFF), val2=1 -> ex_taken=1; BGE with the same operands -> 0. Correctly predicted -> no flush, branch_count+1.
- Mispredict with hazard_detected=1 -> no flush and no counter/BHT change. Deassert hazard the next cycle -> flush follows one cycle later.
- Mispredict followed immediately by a mispredicting ex_valid instruction while flush=1 -> second instruction ignored, single flush pulse. Then stat_clear together with a resolve -> both counters read 0.

Source files
------------

// File: rtl/branch_predict_unit_pkg.sv
// ----------------------------------------------------------------------------
// branch_predict_unit_pkg
// Shared definitions for the branch resolution / prediction unit:
//   - branch condition codes driven on ex_branch_cmd
//   - 2-bit BHT counter state encodings
//   - saturating next-state helper for a BHT counter
// ----------------------------------------------------------------------------
package branch_predict_unit_pkg;

    // Condition codes. Codes 6 and 7 are undefined and behave as CMD_NULL.
    typedef enum logic [2:0] {
        CMD_NULL = 3'd0,
        CMD_JUMP = 3'd1,
        CMD_BEZ  = 3'd2,
        CMD_BNE  = 3'd3,
        CMD_BLT  = 3'd4,
        CMD_BGE  = 3'd5
    } branch_cmd_e;

    // BHT counter states; the MSB is the taken prediction.
    localparam logic [1:0] BHT_SNT = 2'b00;
    localparam logic [1:0] BHT_WNT = 2'b01;
    localparam logic [1:0] BHT_WT  = 2'b10;
    localparam logic [1:0] BHT_ST  = 2'b11;

    // Saturating counter step: towards ST when taken, towards SNT otherwise.
    function automatic logic [1:0] bht_next(input logic [1:0] state, input logic taken);
        if (taken) begin
            return (state == BHT_ST) ? BHT_ST : state + 2'd1;
        end
        return (state == BHT_SNT) ? BHT_SNT : state - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// ----------------------------------------------------------------------------
// branch_predict_unit_if
// Bundles the IF-side prediction lookup, the EX-side branch inputs, the
// flush/redirect outputs and the statistics counters.
//   master : pipeline side (drives fetch PC and EX branch info)
//   slave  : branch_predict_unit
// ----------------------------------------------------------------------------
interface branch_predict_unit_if #(
    parameter int WORD_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int CNT_WIDTH  = 16
) ();

    // IF stage lookup
    logic [PC_WIDTH-1:0]   if_pc;
    logic                  if_pred_taken;

    // EX stage branch
    logic                  ex_valid;
    logic [PC_WIDTH-1:0]   ex_pc;
    logic [2:0]            ex_branch_cmd;
    logic [WORD_WIDTH-1:0] ex_val1;
    logic [WORD_WIDTH-1:0] ex_val2;
    logic [PC_WIDTH-1:0]   ex_target;
    logic                  ex_pred_taken;
    logic                  hazard_detected;
    logic                  ex_taken;

    // Redirect and statistics
    logic                  stat_clear;
    logic                  flush;
    logic [PC_WIDTH-1:0]   redirect_pc;
    logic [CNT_WIDTH-1:0]  branch_count;
    logic [CNT_WIDTH-1:0]  mispredict_count;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_branch_cmd, ex_val1, ex_val2,
               ex_target, ex_pred_taken, hazard_detected, stat_clear,
        input  if_pred_taken, ex_taken, flush, redirect_pc,
               branch_count, mispredict_count
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_branch_cmd, ex_val1, ex_val2,
               ex_target, ex_pred_taken, hazard_detected, stat_clear,
        output if_pred_taken, ex_taken, flush, redirect_pc,
               branch_count, mispredict_count
    );

endinterface

// File: rtl/branch_predict_unit_bht_table.sv
// ----------------------------------------------------------------------------
// branch_predict_unit_bht_table
// Array of 2-bit saturating branch history counters.
//   clk, rst      : clock, asynchronous active-low reset (all entries -> WNT)
//   i_rd_idx      : asynchronous read index
//   o_rd_state    : counter at i_rd_idx (pre-update value, no write bypass)
//   i_wr_en       : apply a saturating update at i_wr_idx on the clock edge
//   i_wr_idx      : update index
//   i_wr_taken    : update direction (1 = towards taken)
// ----------------------------------------------------------------------------
module branch_predict_unit_bht_table
    import branch_predict_unit_pkg::*;
#(
    parameter int ENTRIES  = 16,
    parameter int IDX_BITS = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] i_rd_idx,
    output logic [1:0]          o_rd_state,
    input  logic                i_wr_en,
    input  logic [IDX_BITS-1:0] i_wr_idx,
    input  logic                i_wr_taken
);

    logic [1:0] r_table [ENTRIES];

    // NOTE: the table is a flop array, not a RAM: every entry must come out of
    // reset as WNT, so it is reset explicitly and cannot map to a memory macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= BHT_WNT;
            end
        end else if (i_wr_en) begin
            // NOTE: non-blocking so a same-edge reader sees the old value.
            r_table[i_wr_idx] <= bht_next(r_table[i_wr_idx], i_wr_taken);
        end
    end

    assign o_rd_state = r_table[i_rd_idx];

endmodule

// File: rtl/branch_predict_unit.sv
// ----------------------------------------------------------------------------
// branch_predict_unit
// Resolves EX-stage branch/jump conditions, trains a 2-bit BHT that IF reads,
// raises a registered one-cycle flush with the correct redirect PC on a
// mispredict, and keeps saturating branch / mispredict counters.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : branch_predict_unit_if.slave (IF lookup, EX branch, flush, stats)
// ----------------------------------------------------------------------------
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int WORD_WIDTH  = 32,
    parameter int PC_WIDTH    = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int PC_INC      = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_predict_unit_if.slave bus
);

    localparam int IDX_BITS = $clog2(BHT_ENTRIES);

    logic                 w_taken;
    logic                 w_cmd_real;
    logic                 w_resolve;
    logic                 w_mispredict;
    logic [1:0]           w_rd_state;
    logic [PC_WIDTH-1:0]  w_fallthrough;

    logic                 r_flush;
    logic [PC_WIDTH-1:0]  r_redirect_pc;
    logic [CNT_WIDTH-1:0] r_branch_count;
    logic [CNT_WIDTH-1:0] r_mispredict_count;

    // Condition evaluation. Undefined codes fall to the default and count as
    // NULL, so they neither resolve nor train the table.
    // NOTE: both outputs get defaults first so no path leaves them unassigned
    // and no latch is inferred.
    always_comb begin
        w_taken    = 1'b0;
        w_cmd_real = 1'b0;
        case (bus.ex_branch_cmd)
            CMD_JUMP: begin
                w_taken    = 1'b1;
                w_cmd_real = 1'b1;
            end
            CMD_BEZ: begin
                w_taken    = (bus.ex_val1 == '0);
                w_cmd_real = 1'b1;
            end
            CMD_BNE: begin
                w_taken    = (bus.ex_val1 != bus.ex_val2);
                w_cmd_real = 1'b1;
            end
            CMD_BLT: begin
                w_taken    = ($signed(bus.ex_val1) < $signed(bus.ex_val2));
                w_cmd_real = 1'b1;
            end
            CMD_BGE: begin
                w_taken    = ($signed(bus.ex_val1) >= $signed(bus.ex_val2));
                w_cmd_real = 1'b1;
            end
            default: ;
        endcase
    end

    // The ~r_flush term squashes the wrong-path instruction occupying EX in
    // the flush cycle, which also rules out back-to-back flush pulses.
    assign w_resolve     = bus.ex_valid & w_cmd_real & ~bus.hazard_detected & ~r_flush;
    assign w_mispredict  = w_taken != bus.ex_pred_taken;
    assign w_fallthrough = bus.ex_pc + PC_WIDTH'(PC_INC);

    branch_predict_unit_bht_table #(
        .ENTRIES  (BHT_ENTRIES),
        .IDX_BITS (IDX_BITS)
    ) u_bht (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (bus.if_pc[IDX_BITS-1:0]),
        .o_rd_state (w_rd_state),
        .i_wr_en    (w_resolve),
        .i_wr_idx   (bus.ex_pc[IDX_BITS-1:0]),
        .i_wr_taken (w_taken)
    );

    // Flush is rewritten every edge, so it is high for exactly one cycle.
    // The redirect PC holds its last value when no mispredict resolves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_flush <= w_resolve & w_mispredict;
            if (w_resolve && w_mispredict) begin
                r_redirect_pc <= w_taken ? bus.ex_target : w_fallthrough;
            end
        end
    end

    // Statistics: stat_clear wins over any increment on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (bus.stat_clear) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (w_resolve) begin
            if (r_branch_count != '1) begin
                r_branch_count <= r_branch_count + CNT_WIDTH'(1);
            end
            if (w_mispredict && (r_mispredict_count != '1)) begin
                r_mispredict_count <= r_mispredict_count + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.if_pred_taken    = w_rd_state[1];
    assign bus.ex_taken         = w_taken;
    assign bus.flush            = r_flush;
    assign bus.redirect_pc      = r_redirect_pc;
    assign bus.branch_count     = r_branch_count;
    assign bus.mispredict_count = r_mispredict_count;

    // Only the index bits of the PCs and the counter MSB are consumed.
    logic w_unused_bits;
    assign w_unused_bits = ^{bus.if_pc[PC_WIDTH-1:IDX_BITS],
                             bus.ex_pc[PC_WIDTH-1:IDX_BITS],
                             w_rd_state[0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_predict_unit
// Directed bench for branch_predict_unit. Inputs change on the falling edge;
// outputs are sampled on the falling edge, away from the active rising edge.
// Counters are built 4 bits wide so saturation is reachable in a few cycles.
// ----------------------------------------------------------------------------
module tb_branch_predict_unit;
    import branch_predict_unit_pkg::*;

    localparam int WW = 32;
    localparam int PW = 32;
    localparam int CW = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    branch_predict_unit_if #(.WORD_WIDTH(WW), .PC_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

    branch_predict_unit #(
        .WORD_WIDTH  (WW),
        .PC_WIDTH    (PW),
        .BHT_ENTRIES (16),
        .PC_INC      (1),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.ex_valid        = 1'b0;
        bus.ex_pc           = '0;
        bus.ex_branch_cmd   = CMD_NULL;
        bus.ex_val1         = '0;
        bus.ex_val2         = '0;
        bus.ex_target       = '0;
        bus.ex_pred_taken   = 1'b0;
        bus.hazard_detected = 1'b0;
        bus.stat_clear      = 1'b0;
    endtask

    task automatic branch(input logic [2:0] cmd, input logic [PW-1:0] pc,
                          input logic [WW-1:0] v1, input logic [WW-1:0] v2,
                          input logic [PW-1:0] tgt, input logic pred);
        bus.ex_valid      = 1'b1;
        bus.ex_branch_cmd = cmd;
        bus.ex_pc         = pc;
        bus.ex_val1       = v1;
        bus.ex_val2       = v2;
        bus.ex_target     = tgt;
        bus.ex_pred_taken = pred;
    endtask

    task automatic test_reset();
        total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%0h exp=0", bus.flush); end
        total++; if (bus.redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_redirect got=%0h exp=0", bus.redirect_pc); end
        total++; if (bus.branch_count !== 4'd0) begin bad++; $display("FAIL reset_bcount got=%0d exp=0", bus.branch_count); end
        total++; if (bus.mispredict_count !== 4'd0) begin bad++; $display("FAIL reset_mcount got=%0d exp=0", bus.mispredict_count); end
        for (int i = 0; i < 16; i++) begin
            bus.if_pc = PW'(i);
            #1;
            total++; if (bus.if_pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred idx=%0d got=%0b exp=0", i, bus.if_pred_taken); end
        end
        bus.if_pc = 32'd5;
        #1;
        total++; if (bus.if_pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred5 got=%0b exp=0", bus.if_pred_taken); end
        @(negedge clk);
    endtask

    task automatic test_bez_mispredict();
        branch(CMD_BEZ, 32'd3, 32'd0, 32'd7, 32'h40, 1'b0);
        bus.if_pc = 32'd3;
        #1;
        total++; if (bus.ex_taken !== 1'b1) begin bad++; $display("FAIL bez_taken got=%0b exp=1", bus.ex_taken); end
        // Same-cycle read of the index being written returns the old value.
        total++; if (bus.if_pred_taken !== 1'b0) begin bad++; $display("FAIL bez_nobypass got=%0b exp=0", bus.if_pred_taken); end
        step();
        idle();
        #1;
        total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL bez_flush got=%0b exp=1", bus.flush); end
        total++; if (bus.redirect_pc !== 32'h40) begin bad++; $display("FAIL bez_redirect got=%0h exp=40", bus.redirect_pc); end
        total++; if (bus.mispredict_count !== 4'd1) begin bad++; $display("FAIL bez_mcount got=%0d exp=1", bus.mispredict_count); end
        total++; if (bus.branch_count !== 4'd1) begin bad++; $display("FAIL bez_bcount got=%0d exp=1", bus.branch_count); end
        total++; if (bus.if_pred_taken !== 1'b1) begin bad++; $display("FAIL bez_bht3 got=%0b exp=1", bus.if_pred_taken); end
        step();
        total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL bez_flush_drop got=%0b exp=0", bus.flush); end
    endtask

    task automatic test_bne_saturate();
        branch(CMD_BNE, 32'd7, 32'd9, 32'd9, 32'h80, 1'b1);
        bus.if_pc = 32'd7;
        #1;
        total++; if (bus.ex_taken !== 1'b0) begin bad++; $display("FAIL bne_taken got=%0b exp=0", bus.ex_taken); end
        step();
        idle();
        #1;
        total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL bne_flush got=%0b exp=1", bus.flush); end
        total++; if (bus.redirect_pc !== 32'd8) begin bad++; $display("FAIL bne_redirect got=%0h exp=8", bus.redirect_pc); end
        total++; if (bus.mispredict_count !== 4'd2) begin bad++; $display("FAIL bne_mcount got=%0d exp=2", bus.mispredict_count); end
        step();
        // Four correctly predicted not-taken: BHT[7] must stay at 00.
        for (int i = 0; i < 4; i++) begin
            branch(CMD_BNE, 32'd7, 32'd9, 32'd9, 32'h80, 1'b0);
            step();
            total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL bne_nt_flush i=%0d got=%0b exp=0", i, bus.flush); end
        end
        total++; if (bus.branch_count !== 4'd6) begin bad++; $display("FAIL bne_bcount got=%0d exp=6", bus.branch_count); end
        // One taken step from 00 reaches only 01, still predicting not-taken.
        branch(CMD_BNE, 32'd7, 32'd1, 32'd2, 32'h80, 1'b0);
        step();
        idle();
        #1;
        total++; if (bus.if_pred_taken !== 1'b0) begin bad++; $display("FAIL bne_sat_floor got=%0b exp=0", bus.if_pred_taken); end
        total++; if (bus.redirect_pc !== 32'h80) begin bad++; $display("FAIL bne_redirect2 got=%0h exp=80", bus.redirect_pc); end
        total++; if (bus.mispredict_count !== 4'd3) begin bad++; $display("FAIL bne_mcount2 got=%0d exp=3", bus.mispredict_count); end
        step();
    endtask

    task automatic test_signed();
        branch(CMD_BLT, 32'd9, 32'hFFFF_FFFF, 32'd1, 32'h90, 1'b1);
        #1;
        total++; if (bus.ex_taken !== 1'b1) begin bad++; $display("FAIL blt_taken got=%0b exp=1", bus.ex_taken); end
        step();
        total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL blt_flush got=%0b exp=0", bus.flush); end
        total++; if (bus.branch_count !== 4'd8) begin bad++; $display("FAIL blt_bcount got=%0d exp=8", bus.branch_count); end
        branch(CMD_BGE, 32'd9, 32'hFFFF_FFFF, 32'd1, 32'h90, 1'b0);
        #1;
        total++; if (bus.ex_taken !== 1'b0) begin bad++; $display("FAIL bge_taken got=%0b exp=0", bus.ex_taken); end
        step();
        total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL bge_flush got=%0b exp=0", bus.flush); end
        total++; if (bus.branch_count !== 4'd9) begin bad++; $display("FAIL bge_bcount got=%0d exp=9", bus.branch_count); end
        idle();
        bus.ex_branch_cmd = CMD_JUMP;
        #1;
        total++; if (bus.ex_taken !== 1'b1) begin bad++; $display("FAIL jump_taken got=%0b exp=1", bus.ex_taken); end
        // Undefined codes resolve as NULL: never taken, never counted.
        for (int c = 6; c < 8; c++) begin
            branch(3'(c), 32'd9, 32'd0, 32'd0, 32'h90, 1'b1);
            #1;
            total++; if (bus.ex_taken !== 1'b0) begin bad++; $display("FAIL undef_taken code=%0d got=%0b exp=0", c, bus.ex_taken); end
            step();
            total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL undef_flush code=%0d got=%0b exp=0", c, bus.flush); end
        end
        total++; if (bus.branch_count !== 4'd9) begin bad++; $display("FAIL undef_bcount got=%0d exp=9", bus.branch_count); end
        idle();
    endtask

    task automatic test_hazard();
        branch(CMD_BEZ, 32'd2, 32'd0, 32'd0, 32'h123, 1'b0);
        bus.hazard_detected = 1'b1;
        bus.if_pc = 32'd2;
        #1;
        total++; if (bus.ex_taken !== 1'b1) begin bad++; $display("FAIL haz_taken got=%0b exp=1", bus.ex_taken); end
        step();
        total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL haz_flush got=%0b exp=0", bus.flush); end
        total++; if (bus.branch_count !== 4'd9) begin bad++; $display("FAIL haz_bcount got=%0d exp=9", bus.branch_count); end
        total++; if (bus.mispredict_count !== 4'd3) begin bad++; $display("FAIL haz_mcount got=%0d exp=3", bus.mispredict_count); end
        total++; if (bus.if_pred_taken !== 1'b0) begin bad++; $display("FAIL haz_bht got=%0b exp=0", bus.if_pred_taken); end
        bus.hazard_detected = 1'b0;
        step();
        idle();
        #1;
        total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL haz_rel_flush got=%0b exp=1", bus.flush); end
        total++; if (bus.redirect_pc !== 32'h123) begin bad++; $display("FAIL haz_rel_redirect got=%0h exp=123", bus.redirect_pc); end
        total++; if (bus.mispredict_count !== 4'd4) begin bad++; $display("FAIL haz_rel_mcount got=%0d exp=4", bus.mispredict_count); end
        total++; if (bus.if_pred_taken !== 1'b1) begin bad++; $display("FAIL haz_rel_bht got=%0b exp=1", bus.if_pred_taken); end
        step();
    endtask

    task automatic test_back_to_back();
        branch(CMD_JUMP, 32'd4, 32'd0, 32'd0, 32'h200, 1'b0);
        step();
        total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL b2b_flush1 got=%0b exp=1", bus.flush); end
        total++; if (bus.redirect_pc !== 32'h200) begin bad++; $display("FAIL b2b_redirect1 got=%0h exp=200", bus.redirect_pc); end
        // Wrong-path mispredicting branch sits in EX during the flush cycle.
        branch(CMD_BNE, 32'd5, 32'd1, 32'd2, 32'h300, 1'b0);
        bus.if_pc = 32'd5;
        step();
        idle();
        #1;
        total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL b2b_flush2 got=%0b exp=0", bus.flush); end
        total++; if (bus.redirect_pc !== 32'h200) begin bad++; $display("FAIL b2b_redirect2 got=%0h exp=200", bus.redirect_pc); end
        total++; if (bus.branch_count !== 4'd11) begin bad++; $display("FAIL b2b_bcount got=%0d exp=11", bus.branch_count); end
        total++; if (bus.mispredict_count !== 4'd5) begin bad++; $display("FAIL b2b_mcount got=%0d exp=5", bus.mispredict_count); end
        total++; if (bus.if_pred_taken !== 1'b0) begin bad++; $display("FAIL b2b_bht5 got=%0b exp=0", bus.if_pred_taken); end
    endtask

    task automatic test_stat_clear();
        branch(CMD_BEZ, 32'd6, 32'd0, 32'd0, 32'h60, 1'b1);
        bus.stat_clear = 1'b1;
        step();
        bus.stat_clear = 1'b0;
        idle();
        bus.if_pc = 32'd6;
        #1;
        total++; if (bus.branch_count !== 4'd0) begin bad++; $display("FAIL clr_bcount got=%0d exp=0", bus.branch_count); end
        total++; if (bus.mispredict_count !== 4'd0) begin bad++; $display("FAIL clr_mcount got=%0d exp=0", bus.mispredict_count); end
        total++; if (bus.if_pred_taken !== 1'b1) begin bad++; $display("FAIL clr_bht6 got=%0b exp=1", bus.if_pred_taken); end
        branch(CMD_JUMP, 32'd10, 32'd0, 32'd0, 32'hA0, 1'b1);
        step();
        total++; if (bus.branch_count !== 4'd1) begin bad++; $display("FAIL clr_resume got=%0d exp=1", bus.branch_count); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            branch(CMD_JUMP, 32'd10, 32'd0, 32'd0, 32'hA0, 1'b1);
            step();
        end
        idle();
        total++; if (bus.branch_count !== 4'd15) begin bad++; $display("FAIL sat_bcount got=%0d exp=15", bus.branch_count); end
        total++; if (bus.mispredict_count !== 4'd0) begin bad++; $display("FAIL sat_mcount got=%0d exp=0", bus.mispredict_count); end
    endtask

    task automatic test_async_reset();
        branch(CMD_BEZ, 32'd3, 32'd0, 32'd0, 32'h55, 1'b0);
        step();
        idle();
        bus.if_pc = 32'd3;
        #1;
        total++; if (bus.flush !== 1'b1) begin bad++; $display("FAIL arst_pre_flush got=%0b exp=1", bus.flush); end
        rst = 1'b0;
        #1;
        total++; if (bus.flush !== 1'b0) begin bad++; $display("FAIL arst_flush got=%0b exp=0", bus.flush); end
        total++; if (bus.redirect_pc !== 32'h0) begin bad++; $display("FAIL arst_redirect got=%0h exp=0", bus.redirect_pc); end
        total++; if (bus.branch_count !== 4'd0) begin bad++; $display("FAIL arst_bcount got=%0d exp=0", bus.branch_count); end
        total++; if (bus.if_pred_taken !== 1'b0) begin bad++; $display("FAIL arst_bht3 got=%0b exp=0", bus.if_pred_taken); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        idle();
        bus.if_pc = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        test_reset();
        test_bez_mispredict();
        test_bne_saturate();
        test_signed();
        test_hazard();
        test_back_to_back();
        test_stat_clear();
        test_saturation();
        test_async_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
